// File: rtl/conv_v2_pkg.sv
// Shared types and sizing helpers for the conv_v2 window generator.
package conv_v2_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_KERNEL_X = 3;
  localparam int DEF_KERNEL_Y = 3;

  // Window of the default build; parameterised instances declare the same shape locally.
  typedef logic [DEF_KERNEL_Y-1:0][DEF_KERNEL_X-1:0][DEF_DATA_W-1:0] window_t;

  function automatic int f_cnt_w(input int w, input int h);
    int m;
    m = (w > h) ? w : h;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int f_lines(input int ky);
    return ky - 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Line store: pDEPTH columns, each holding the last pLINES pixels seen at that column.
// Reading and writing a column happen in the same access, old contents first.
import conv_v2_pkg::*;

module conv_line_buffer #(
  parameter int pDATA_W = 8,
  parameter int pLINES  = 2,
  parameter int pDEPTH  = 32,
  parameter int pADDR_W = 5
) (
  input  logic                        iclk,
  input  logic                        iwr_en,
  input  logic [pADDR_W-1:0]          iaddr,
  input  logic [pDATA_W-1:0]          idata,
  output logic [pLINES*pDATA_W-1:0]   ordata
);

  logic [pLINES*pDATA_W-1:0] mem [pDEPTH];
  logic [pLINES*pDATA_W-1:0] wr_data;

  assign ordata = mem[iaddr];

  // Line k moves to line k+1; the incoming pixel becomes line 0.
  if (pLINES > 1) begin : g_shift
    assign wr_data = {ordata[(pLINES-1)*pDATA_W-1:0], idata};
  end else begin : g_single
    assign wr_data = idata;
  end

  always_ff @(posedge iclk) begin
    if (iwr_en) mem[iaddr] <= wr_data;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KY x KX sliding-window generator for raster-order pixels.
// Optional frame-sync checking is enabled with CONV_WINDOW_GEN_FRAME_CHECK_EN.
import conv_v2_pkg::*;

module conv_window_gen #(
  parameter int pDATA_W   = 8,
  parameter int pKERNEL_X = 3,
  parameter int pKERNEL_Y = 3,
  parameter int pIMG_W    = 32,
  parameter int pIMG_H    = 32
) (
  input  logic                                            iclk,
  input  logic                                            irst,
  input  logic [pDATA_W-1:0]                              idata,
  input  logic                                            ivalid,
  input  logic                                            isof,
  output logic [pKERNEL_Y-1:0][pKERNEL_X-1:0][pDATA_W-1:0] owindow,
  output logic                                            owin_valid,
  output logic                                            owin_last,
  output logic                                            oframe_err
);

  localparam int lpCNT_W  = f_cnt_w(pIMG_W, pIMG_H);
  localparam int lpLINES  = f_lines(pKERNEL_Y);
  localparam int lpADDR_W = f_cnt_w(pIMG_W, 1);
  localparam logic [lpCNT_W-1:0] LAST_C = lpCNT_W'(pIMG_W - 1);
  localparam logic [lpCNT_W-1:0] LAST_R = lpCNT_W'(pIMG_H - 1);

  logic [lpCNT_W-1:0] col_cnt, row_cnt;
  logic [lpCNT_W-1:0] pos_c, pos_r;
  logic               win_ok, pos_last;
  logic [pKERNEL_Y-1:0][pDATA_W-1:0] new_col;

  // isof overrides the counters so a new frame can start anywhere.
  assign pos_c    = isof ? '0 : col_cnt;
  assign pos_r    = isof ? '0 : row_cnt;
  assign win_ok   = (int'(pos_r) >= pKERNEL_Y - 1) && (int'(pos_c) >= pKERNEL_X - 1);
  assign pos_last = (pos_r == LAST_R) && (pos_c == LAST_C);

  assign new_col[pKERNEL_Y-1] = idata;

  if (lpLINES > 0) begin : g_lb
    logic [lpLINES*pDATA_W-1:0] lb_rd;

    conv_line_buffer #(
      .pDATA_W (pDATA_W),
      .pLINES  (lpLINES),
      .pDEPTH  (pIMG_W),
      .pADDR_W (lpADDR_W)
    ) u_line_buffer (
      .iclk   (iclk),
      .iwr_en (ivalid),
      .iaddr  (pos_c[lpADDR_W-1:0]),
      .idata  (idata),
      .ordata (lb_rd)
    );

    // Line k is row r-1-k, i.e. window row KY-2-k.
    for (genvar k = 0; k < lpLINES; k++) begin : g_tap
      assign new_col[pKERNEL_Y-2-k] = lb_rd[k*pDATA_W +: pDATA_W];
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (ivalid) begin
      if (pos_c == LAST_C) begin
        col_cnt <= '0;
        row_cnt <= (pos_r == LAST_R) ? '0 : pos_r + 1'b1;
      end else begin
        col_cnt <= pos_c + 1'b1;
        row_cnt <= pos_r;
      end
    end
  end

  // The window register doubles as the horizontal shift array.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      owindow    <= '0;
      owin_valid <= 1'b0;
      owin_last  <= 1'b0;
    end else begin
      owin_valid <= ivalid && win_ok;
      owin_last  <= ivalid && pos_last;
      if (ivalid) begin
        for (int y = 0; y < pKERNEL_Y; y++) begin
          for (int x = 0; x < pKERNEL_X - 1; x++) begin
            owindow[y][x] <= owindow[y][x+1];
          end
          owindow[y][pKERNEL_X-1] <= new_col[y];
        end
      end
    end
  end

`ifdef CONV_WINDOW_GEN_FRAME_CHECK_EN
  logic frame_done;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      frame_done <= 1'b0;
      oframe_err <= 1'b0;
    end else begin
      oframe_err <= 1'b0;
      if (ivalid) begin
        frame_done <= pos_last;
        oframe_err <= (isof && ((col_cnt != '0) || (row_cnt != '0))) ||
                      (!isof && (col_cnt == '0) && (row_cnt == '0) && frame_done);
      end
    end
  end
`else
  assign oframe_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench: 3x3 and 1x1 generators on a 5x4 image with pixel = {row, col}.
module tb_conv_window_gen;

`ifdef CONV_WINDOW_GEN_FRAME_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        iclk = 1'b0;
  logic        irst;
  logic [7:0]  idata;
  logic        ivalid;
  logic        isof;
  logic [2:0][2:0][7:0] owindow;
  logic        owin_valid, owin_last, oframe_err;
  logic [0:0][0:0][7:0] k1_window;
  logic        k1_valid, k1_last, k1_err;

  int n_total = 0;
  int n_bad   = 0;
  int nwin;
  bit prev_valid = 1'b0;
  logic [2:0][2:0][7:0] last_win;
  logic [7:0] last_pix;

  always #5 iclk = ~iclk;

  conv_window_gen #(
    .pDATA_W(8), .pKERNEL_X(3), .pKERNEL_Y(3), .pIMG_W(5), .pIMG_H(4)
  ) dut (
    .iclk(iclk), .irst(irst), .idata(idata), .ivalid(ivalid), .isof(isof),
    .owindow(owindow), .owin_valid(owin_valid), .owin_last(owin_last),
    .oframe_err(oframe_err)
  );

  conv_window_gen #(
    .pDATA_W(8), .pKERNEL_X(1), .pKERNEL_Y(1), .pIMG_W(5), .pIMG_H(4)
  ) dut_k1 (
    .iclk(iclk), .irst(irst), .idata(idata), .ivalid(ivalid), .isof(isof),
    .owindow(k1_window), .owin_valid(k1_valid), .owin_last(k1_last),
    .oframe_err(k1_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0][2:0][7:0] exp_win(input int r, input int c);
    logic [2:0][2:0][7:0] w;
    int rr, cc;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 3; x++) begin
        rr = r - 2 + y;
        cc = c - 2 + x;
        w[y][x] = {rr[3:0], cc[3:0]};
      end
    end
    return w;
  endfunction

  task automatic px(input int r, input int c, input bit sof, input bit err);
    logic [7:0] p;
    bit v;
    p = {r[3:0], c[3:0]};
    v = (r >= 2) && (c >= 2);
    idata  = p;
    ivalid = 1'b1;
    isof   = sof;
    @(posedge iclk); #1;
    chk("valid", 128'(owin_valid), 128'(v));
    chk("last", 128'(owin_last), 128'((r == 3) && (c == 4)));
    chk("err", 128'(oframe_err), 128'(err && ERR_EN));
    if (v) begin
      last_win = exp_win(r, c);
      chk("window", 128'(owindow), 128'(last_win));
      nwin++;
    end
    chk("k1_valid", 128'(k1_valid), 128'(1));
    chk("k1_win", 128'(k1_window), 128'(p));
    chk("k1_last", 128'(k1_last), 128'((r == 3) && (c == 4)));
    chk("k1_err", 128'(k1_err), 128'(err && ERR_EN));
    prev_valid = v;
    last_pix = p;
  endtask

  task automatic idle();
    idata  = 8'($urandom);
    ivalid = 1'b0;
    isof   = 1'b0;
    @(posedge iclk); #1;
    chk("idle_valid", 128'(owin_valid), 128'(0));
    chk("idle_last", 128'(owin_last), 128'(0));
    if (prev_valid) chk("hold", 128'(owindow), 128'(last_win));
    chk("k1_idle_valid", 128'(k1_valid), 128'(0));
    chk("k1_hold", 128'(k1_window), 128'(last_pix));
  endtask

  task automatic run_frame(input bit sof, input bit gap, input bit err0);
    nwin = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        px(r, c, sof && (r == 0) && (c == 0), err0 && (r == 0) && (c == 0));
        if (gap) idle();
      end
    end
    chk("nwin", 128'(nwin), 128'(6));
  endtask

  initial begin
    irst   = 1'b1;
    idata  = '0;
    ivalid = 1'b0;
    isof   = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_valid", 128'(owin_valid), 128'(0));
    chk("rst_last", 128'(owin_last), 128'(0));
    chk("rst_err", 128'(oframe_err), 128'(0));
    chk("rst_window", 128'(owindow), 128'(0));
    chk("rst_k1_window", 128'(k1_window), 128'(0));
    irst = 1'b0;

    // Continuous frame; then gapped frame; then a frame with no isof.
    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1);

    // Frame restarted by isof at (2,1).
    nwin = 0;
    px(0, 0, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 5; c++)
        if (r != 0 || c != 0) px(r, c, 1'b0, 1'b0);
    px(2, 0, 1'b0, 1'b0);
    chk("partial_nwin", 128'(nwin), 128'(0));
    run_frame(1'b1, 1'b0, 1'b1);

    // Asynchronous reset part-way through row 3.
    px(0, 0, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if ((r != 0 || c != 0) && (r < 3 || c < 3)) px(r, c, 1'b0, 1'b0);
    chk("pre_rst_valid", 128'(owin_valid), 128'(1));
    ivalid = 1'b0;
    #2 irst = 1'b1;
    #1;
    chk("arst_valid", 128'(owin_valid), 128'(0));
    chk("arst_window", 128'(owindow), 128'(0));
    chk("arst_k1_window", 128'(k1_window), 128'(0));
    @(posedge iclk); #1;
    irst = 1'b0;
    prev_valid = 1'b0;
    last_pix = '0;
    run_frame(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
